aes_key_schedule_ctrl: RTL and testbench
========================================

# aes_key_schedule_ctrl

Sequencer and round-key store for AES-128 key expansion. Accepts a 128-bit cipher key over a valid/ready handshake and steps four chained `Keyword_gen` instances one round per cycle. Writes round keys 0..10 into an internal 11×128 register file. Serves them to the cipher core through a registered, round-indexed read port, and is the single owner of key-expansion sequencing in the AES datapath.

## Interface
- No parameters (AES-128 only: 11 round keys, 4 words per round).
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `key_valid`  in  1  cipher key offered
- `key_ready`  out  1  block can accept a key
- `key_in`  in  128  cipher key, word 0 = [127:96]
- `keys_valid`  out  1  all 11 round keys stored and readable
- `busy`  out  1  expansion in progress
- `rd_en`  in  1  round-key read request
- `rd_round`  in  4  round index 0..10
- `rd_valid`  out  1  read response strobe, one cycle after `rd_en`
- `rd_key`  out  128  round key for the requested round
- `rd_err`  out  1  response is invalid (bad index or key not available)

## Operation
- States: IDLE, EXPAND, READY.
- Round counter `cnt` is 4 bits, range 1..10.
- **IDLE**
  - `key_ready=1`.
  - On `key_valid & key_ready`: rk[0] ← `key_in`, `cnt` ← 1, go to EXPAND.
- **EXPAND**
  - `key_ready=0`, `busy=1`.
  - Each cycle: words W0..W3 come from the chained `Keyword_gen` instances.
    - Instance k: `i = {cnt,2'dk}` (6 bits).
    - `prev_period_word` = word k of rk[cnt-1].
    - `prev_word` = rk[cnt-1][31:0] for k=0; otherwise the previous instance's output.
  - rk[cnt] ← {W0,W1,W2,W3}, `cnt` ← `cnt`+1.
  - When `cnt==10` the write completes, then go to READY. `cnt` never exceeds 10.
- **READY**
  - `keys_valid=1`, `key_ready=1`.
  - Accepting a new key: writes rk[0], clears `keys_valid` at the same edge, goes to EXPAND with `cnt=1`.
- **Read port**
  - Sampled every cycle regardless of state.
  - The response is registered. `rd_valid` is high exactly one cycle after each `rd_en`.
  - `rd_round > 10`: `rd_err=1`, `rd_key=0`.
  - Read when the round is not available (see Configuration): `rd_err=1`, `rd_key=0`.
  - Otherwise: `rd_err=0`, `rd_key` = rk[`rd_round`].
- **Simultaneous read and key accept in READY**: the read returns the old contents of rk[`rd_round`] (pre-edge value), with `rd_err=0`.
- `key_valid` while `key_ready=0` is ignored. The key is not latched and must be held by the source.

## Timing
- **Reset**
  - state=IDLE, `cnt`=0.
  - `key_ready=1`, `keys_valid=0`, `busy=0`.
  - `rd_valid=0`, `rd_err=0`, `rd_key=0`.
  - rk[] is not cleared; it is unreadable until `keys_valid`.
- **Reset mid-expansion**: aborts. The next cycle is IDLE with `keys_valid=0`.
- **Key acceptance** at edge E0; rk[n] is written at edge En (n=1..10).
- `keys_valid` is high from the cycle after E10: a latency of 10 cycles after acceptance and 11 cycles between back-to-back keys.
- `busy` is high for exactly 10 cycles per key.
- Read latency is 1 cycle. One read per cycle is sustained with no bubbles.
- `key_ready` is combinational from state only, with no dependency on `key_valid`.

## Configuration
- Macro: `AES_KEYSCHED_EARLY_READ_EN`.
- **Defined**
  - Reads during EXPAND succeed for any `rd_round < cnt`, i.e. rounds already written.
  - Rounds ≥ `cnt` return `rd_err=1`.
  - This lets the cipher core start round 0 on the cycle after key acceptance.
  - In IDLE after reset, all reads err.
- **Undefined**: any read while `keys_valid=0` returns `rd_err=1`, `rd_key=0`.

## Test plan
- Reset, then key 2b7e151628aed2a6abf7158809cf4f3c accepted. Check:
  - `busy` high for 10 cycles.
  - `keys_valid` rises 10 cycles after acceptance.
  - Read round 1 returns a0fafe1788542cb123a339392a6c7605.
  - Read round 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key 000102030405060708090a0b0c0d0e0f, then read round 10 → 13111d7fe3944a17f307a78b4d2b30c5. Read round 0 → the key itself.
- `rd_round=11` and `rd_round=15` in READY → `rd_valid=1`, `rd_err=1`, `rd_key=0`.
- During EXPAND, hold `key_valid=1` with a different key → `key_ready=0`, key ignored, final round 10 unchanged.
- In READY, read round 10 and accept a new key at the same edge → old round-10 value returned. `keys_valid=0` next cycle, then 10 cycles later the new round-10 key is returned.
- Assert `reset` on the 5th EXPAND cycle → next cycle IDLE, `keys_valid=0`, reads err.
- Early read, macro-dependent:
  - Macro defined: read round 3 at the 4th EXPAND cycle → correct key, `rd_err=0`.
  - Macro undefined: same read → `rd_err=1`.

Source files
------------

// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-load and round-key read bus between the AES key schedule and its users.
interface aes_key_schedule_ctrl_if;
   localparam int unsigned KEY_W   = 128;
   localparam int unsigned ROUND_W = 4;

   logic               key_valid;
   logic               key_ready;
   logic [KEY_W-1:0]   key_in;
   logic               keys_valid;
   logic               busy;
   logic               rd_en;
   logic [ROUND_W-1:0] rd_round;
   logic               rd_valid;
   logic [KEY_W-1:0]   rd_key;
   logic               rd_err;

   modport master (
      output key_valid, key_in, rd_en, rd_round,
      input  key_ready, keys_valid, busy, rd_valid, rd_key, rd_err
   );

   modport slave (
      input  key_valid, key_in, rd_en, rd_round,
      output key_ready, keys_valid, busy, rd_valid, rd_key, rd_err
   );
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key expansion sequencer with an 11-entry round-key store and registered read port.
// Optional feature macro AES_KEYSCHED_EARLY_READ_EN: serve already-written rounds during expansion.

// One AES-128 key-expansion word: w[i] = w[i-4] ^ f(w[i-1]).
module keyword_gen (
   input  logic [5:0]  i,
   input  logic [31:0] prev_word,
   input  logic [31:0] prev_period_word,
   output logic [31:0] word
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      return SBOX[11'(11'd2047 - 11'(x) * 11'd8) -: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [31:0] rot;
   logic [31:0] temp;

   always_comb begin
      rot  = {prev_word[23:0], prev_word[31:24]};
      temp = prev_word;
      if (i[1:0] == 2'd0) begin
         temp = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
                 sub_byte(rot[15:8]),  sub_byte(rot[7:0])} ^ {rcon(i[5:2]), 24'd0};
      end
      word = prev_period_word ^ temp;
   end
endmodule

module aes_key_schedule_ctrl (
   input logic                   clk,
   input logic                   reset,
   aes_key_schedule_ctrl_if.slave bus
);
   localparam int unsigned KEY_W    = 128;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned N_ROUNDS = 11;
   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(10);

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [KEY_W-1:0]   rk [N_ROUNDS];
   logic               rk_we;
   logic [CNT_W-1:0]   rk_widx;
   logic [KEY_W-1:0]   rk_wdata;
   logic [CNT_W-1:0]   prev_idx;
   logic [KEY_W-1:0]   prev_key;
   logic [WORD_W-1:0]  w0, w1, w2, w3;
   logic               rd_avail;
   logic               rd_ok;
   logic [CNT_W-1:0]   rd_idx;
   logic               rd_valid_q;
   logic               rd_err_q;
   logic [KEY_W-1:0]   rd_key_q;

   // Handshake and status are pure decodes of the state register.
   assign bus.key_ready  = (state == IDLE) || (state == READY);
   assign bus.keys_valid = (state == READY);
   assign bus.busy       = (state == EXPAND);
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_err     = rd_err_q;
   assign bus.rd_key     = rd_key_q;

   assign prev_idx = (cnt == '0) ? '0 : CNT_W'(cnt - CNT_W'(1));
   assign prev_key = rk[prev_idx];

   // Four chained word generators produce one full round key per cycle.
   keyword_gen u_kw0 (.i({cnt, 2'd0}), .prev_word(prev_key[31:0]), .prev_period_word(prev_key[127:96]), .word(w0));
   keyword_gen u_kw1 (.i({cnt, 2'd1}), .prev_word(w0),             .prev_period_word(prev_key[95:64]),  .word(w1));
   keyword_gen u_kw2 (.i({cnt, 2'd2}), .prev_word(w1),             .prev_period_word(prev_key[63:32]),  .word(w2));
   keyword_gen u_kw3 (.i({cnt, 2'd3}), .prev_word(w2),             .prev_period_word(prev_key[31:0]),   .word(w3));

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rk_we      = 1'b0;
      rk_widx    = cnt;
      rk_wdata   = {w0, w1, w2, w3};
      case (state)
         IDLE, READY: begin
            if (bus.key_valid) begin
               state_next = EXPAND;
               cnt_next   = CNT_W'(1);
               rk_we      = 1'b1;
               rk_widx    = '0;
               rk_wdata   = bus.key_in;
            end
         end
         EXPAND: begin
            rk_we = 1'b1;
            if (cnt == LAST_ROUND) state_next = READY;
            else                   cnt_next   = CNT_W'(cnt + CNT_W'(1));
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Key store is deliberately not reset; availability is tracked by state.
   always_ff @(posedge clk) begin
      if (rk_we) rk[rk_widx] <= rk_wdata;
   end

`ifdef AES_KEYSCHED_EARLY_READ_EN
   assign rd_avail = (state == READY) || ((state == EXPAND) && (bus.rd_round < cnt));
`else
   assign rd_avail = (state == READY);
`endif

   assign rd_ok  = (bus.rd_round <= LAST_ROUND) && rd_avail;
   assign rd_idx = (bus.rd_round <= LAST_ROUND) ? bus.rd_round : '0;

   // Read response sees pre-edge store contents, so a same-edge key load returns old data.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_key_q   <= '0;
      end else begin
         rd_valid_q <= bus.rd_en;
         rd_err_q   <= bus.rd_en && !rd_ok;
         rd_key_q   <= (bus.rd_en && rd_ok) ? rk[rd_idx] : '0;
      end
   end
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Bench for aes_key_schedule_ctrl: known-answer table, corner sequences, random keys vs. a FIPS-197 model.
module tb_aes_key_schedule_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   aes_key_schedule_ctrl_if bus ();
   aes_key_schedule_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   round;
      logic         err;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [6];
   logic [7:0] sbox_m [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int k = 0; k < 4; k++) w[k] = key[127 - 32*k -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'd0};
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic accept_key(input logic [127:0] key);
      bus.key_valid = 1'b1;
      bus.key_in    = key;
      tick();
      bus.key_valid = 1'b0;
   endtask

   // Accept a key, then count busy cycles and keys_valid latency (sample n=1 is the cycle after acceptance).
   task automatic load_key(input logic [127:0] key);
      int busy_cycles = 0;
      int kv_lat = 0;
      accept_key(key);
      for (int n = 1; n <= 40; n++) begin
         if (bus.busy) busy_cycles++;
         if (bus.keys_valid) begin
            kv_lat = n;
            break;
         end
         tick();
      end
      chk("busy_cycles", 128'(busy_cycles), 128'd10);
      chk("keys_valid_latency", 128'(kv_lat), 128'd11);
   endtask

   task automatic read_chk(input string name, input logic [3:0] round, input logic exp_err,
                           input logic [127:0] exp_key);
      bus.rd_en    = 1'b1;
      bus.rd_round = round;
      tick();
      bus.rd_en = 1'b0;
      chk({name, ".rd_valid"}, 128'(bus.rd_valid), 128'd1);
      chk({name, ".rd_err"},   128'(bus.rd_err),   128'(exp_err));
      chk({name, ".rd_key"},   bus.rd_key,         exp_key);
   endtask

   initial begin
      logic [127:0] loaded;
      logic         have_key;
      logic [127:0] ka, kb, kc;
      logic         kr_seen;
      int           lat;

      bus.key_valid = 1'b0;
      bus.key_in    = '0;
      bus.rd_en     = 1'b0;
      bus.rd_round  = '0;
      reset         = 1'b1;
      build_sbox();

      vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,  1'b0, 128'ha0fafe1788542cb123a339392a6c7605};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd10, 1'b0, 128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd0,  1'b0, 128'h000102030405060708090a0b0c0d0e0f};
      vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd11, 1'b1, 128'h0};
      vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 4'd15, 1'b1, 128'h0};

      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;

      chk("reset.key_ready",  128'(bus.key_ready),  128'd1);
      chk("reset.keys_valid", 128'(bus.keys_valid), 128'd0);
      chk("reset.busy",       128'(bus.busy),       128'd0);
      chk("reset.rd_valid",   128'(bus.rd_valid),   128'd0);
      chk("reset.rd_err",     128'(bus.rd_err),     128'd0);
      chk("reset.rd_key",     bus.rd_key,           128'd0);
      read_chk("idle_read", 4'd0, 1'b1, 128'd0);

      // Known-answer table.
      have_key = 1'b0;
      loaded   = '0;
      for (int v = 0; v < 6; v++) begin
         if (!have_key || loaded !== vecs[v].key) begin
            load_key(vecs[v].key);
            loaded   = vecs[v].key;
            have_key = 1'b1;
         end
         read_chk($sformatf("vec%0d", v), vecs[v].round, vecs[v].err, vecs[v].exp);
      end
      tick();
      chk("rd_valid_idle_cycle", 128'(bus.rd_valid), 128'd0);

      // key_valid held with a different key during expansion must be ignored.
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = ~ka;
      accept_key(ka);
      bus.key_valid = 1'b1;
      bus.key_in    = kb;
      kr_seen = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (bus.busy && bus.key_ready) kr_seen = 1'b1;
         if (bus.keys_valid) break;
         tick();
      end
      bus.key_valid = 1'b0;
      chk("key_ready_during_expand", 128'(kr_seen), 128'd0);
      read_chk("held_key_ignored", 4'd10, 1'b0, model_rk(ka, 10));

      // Same-edge read and key accept in READY returns the old round key.
      bus.key_valid = 1'b1;
      bus.key_in    = kb;
      bus.rd_en     = 1'b1;
      bus.rd_round  = 4'd10;
      tick();
      bus.key_valid = 1'b0;
      bus.rd_en     = 1'b0;
      chk("overlap.rd_valid",   128'(bus.rd_valid),   128'd1);
      chk("overlap.rd_err",     128'(bus.rd_err),     128'd0);
      chk("overlap.rd_key",     bus.rd_key,           model_rk(ka, 10));
      chk("overlap.keys_valid", 128'(bus.keys_valid), 128'd0);
      chk("overlap.busy",       128'(bus.busy),       128'd1);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         if (bus.keys_valid) begin
            lat = n;
            break;
         end
         tick();
      end
      chk("overlap.kv_latency", 128'(lat), 128'd11);
      read_chk("overlap.new_r10", 4'd10, 1'b0, model_rk(kb, 10));

      // Early read at the 4th expand cycle, then reset on the 5th.
      kc = {$urandom, $urandom, $urandom, $urandom};
      accept_key(kc);
      tick();
      tick();
      tick();
      bus.rd_en    = 1'b1;
      bus.rd_round = 4'd3;
      tick();
      bus.rd_en = 1'b0;
      chk("early.rd_valid", 128'(bus.rd_valid), 128'd1);
`ifdef AES_KEYSCHED_EARLY_READ_EN
      chk("early.rd_err", 128'(bus.rd_err), 128'd0);
      chk("early.rd_key", bus.rd_key,       model_rk(kc, 3));
`else
      chk("early.rd_err", 128'(bus.rd_err), 128'd1);
      chk("early.rd_key", bus.rd_key,       128'd0);
`endif
      chk("mid.busy_before_reset", 128'(bus.busy), 128'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_reset.keys_valid", 128'(bus.keys_valid), 128'd0);
      chk("mid_reset.busy",       128'(bus.busy),       128'd0);
      chk("mid_reset.key_ready",  128'(bus.key_ready),  128'd1);
      read_chk("mid_reset.r0", 4'd0, 1'b1, 128'd0);
      read_chk("mid_reset.r3", 4'd3, 1'b1, 128'd0);

      // Random keys against the reference model.
      for (int t = 0; t < 5; t++) begin
         ka = {$urandom, $urandom, $urandom, $urandom};
         load_key(ka);
         for (int r = 0; r <= 10; r++)
            read_chk($sformatf("rand%0d.r%0d", t, r), 4'(r), 1'b0, model_rk(ka, r));
         read_chk($sformatf("rand%0d.oob", t), 4'($urandom_range(11, 15)), 1'b1, 128'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
